// File: rtl/spram_fifo_ctrl.sv
// rtl/spram_fifo_ctrl.sv - FIFO controller over a single-port synchronous RAM
//
// Turns one single-port RAM (one access per cycle, registered read data with
// 1-cycle latency) into a FIFO. Writes and reads share the RAM port under
// round-robin arbitration; read data lands in a 2-entry output skid buffer so
// the read side can stream one word per cycle.
//
// Ports:
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   wr_valid/wr_data  producer word in; wr_ready high when it is accepted
//   rd_valid/rd_data  head word out; popped when rd_valid && rd_ready
//   ram_we/ram_addr   RAM port control; ram_din mirrors wr_data
//   ram_dout          RAM registered read data (valid 1 cycle after a read)
//   level             words held in RAM + in flight + output buffer
//   full, empty       RAM occupancy full / nothing held anywhere
module spram_fifo_ctrl #(
  parameter int DATA = 16,
  parameter int ADDR = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA-1:0]   wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA-1:0]   rd_data,
  input  logic              rd_ready,
  output logic              ram_we,
  output logic [ADDR-1:0]   ram_addr,
  output logic [DATA-1:0]   ram_din,
  input  logic [DATA-1:0]   ram_dout,
  output logic [ADDR+1:0]   level,
  output logic              full,
  output logic              empty
);

  localparam int LVLW = ADDR + 2;
  localparam logic [ADDR:0] MEM_FULL = {1'b1, {ADDR{1'b0}}};

  typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]   mem_cnt_q, mem_cnt_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      out_cnt_q, out_cnt_d;
  logic [DATA-1:0] buf0_q, buf0_d;
  logic [DATA-1:0] buf1_q, buf1_d;
  grant_e          last_grant_q, last_grant_d;

  logic            pop;
  logic            wreq;
  logic            rreq;
  logic [2:0]      credit;
  logic            grant_wr;
  logic            grant_rd;

  assign full     = (mem_cnt_q == MEM_FULL);
  assign rd_valid = (out_cnt_q != 2'd0);
  assign rd_data  = buf0_q;
  assign pop      = rd_valid && rd_ready;
  assign wreq     = wr_valid && !full;

  // Buffer slots already spoken for after this cycle's pop; a new read may be
  // issued only if its return data is guaranteed a free slot.
  assign credit = {1'b0, out_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rreq   = (mem_cnt_q != '0) && (credit < 3'd2);

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (wreq && rreq) begin
      grant_wr = (last_grant_q == GRANT_RD);
      grant_rd = (last_grant_q == GRANT_WR);
    end else begin
      grant_wr = wreq;
      grant_rd = rreq;
    end
  end

  // Gated by rst_n so nothing is accepted or written while reset is held,
  // even before the first reset edge has cleared the state.
  assign wr_ready = grant_wr && rst_n;
  assign ram_we   = grant_wr && rst_n;
  assign ram_addr = grant_wr ? wr_ptr_q : rd_ptr_q;
  assign ram_din  = wr_data;

  assign level = LVLW'(mem_cnt_q) + LVLW'(inflight_q) + LVLW'(out_cnt_q);
  assign empty = (level == '0);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    mem_cnt_d    = mem_cnt_q;
    last_grant_d = last_grant_q;
    inflight_d   = grant_rd;
    if (grant_wr) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      mem_cnt_d    = mem_cnt_q + 1'b1;
      last_grant_d = GRANT_WR;
    end else if (grant_rd) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      mem_cnt_d    = mem_cnt_q - 1'b1;
      last_grant_d = GRANT_RD;
    end
  end

  // Output skid buffer: buf0 is the head. Returning RAM data goes to the
  // first free slot after any simultaneous pop has shifted buf1 forward.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    out_cnt_d = out_cnt_q;
    case ({inflight_q, pop})
      2'b10: begin
        if (out_cnt_q == 2'd0) buf0_d = ram_dout;
        else                   buf1_d = ram_dout;
        out_cnt_d = out_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        out_cnt_d = out_cnt_q - 2'd1;
      end
      2'b11: begin
        if (out_cnt_q == 2'd1) begin
          buf0_d = ram_dout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_dout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      out_cnt_q    <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      last_grant_q <= GRANT_RD;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      inflight_q   <= inflight_d;
      out_cnt_q    <= out_cnt_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// tb/tb_spram_fifo_ctrl.sv - directed self-checking bench for spram_fifo_ctrl
module tb_spram_fifo_ctrl;

  localparam int DATA = 16;
  localparam int ADDR = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_valid;
  logic [DATA-1:0] wr_data;
  logic            wr_ready;
  logic            rd_valid;
  logic [DATA-1:0] rd_data;
  logic            rd_ready;
  logic            ram_we;
  logic [ADDR-1:0] ram_addr;
  logic [DATA-1:0] ram_din;
  logic [DATA-1:0] ram_dout;
  logic [ADDR+1:0] level;
  logic            full;
  logic            empty;

  spram_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .level(level), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  logic [DATA-1:0] mem [0:(1<<ADDR)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  int              n_checks = 0;
  int              n_fail   = 0;
  int              accepts  = 0;
  int              pops     = 0;
  logic [DATA-1:0] next_data;
  logic [DATA-1:0] held;
  logic [DATA-1:0] last_pop;
  bit              hold_chk = 0;
  logic            s_we;
  logic            s_wrr;
  logic [ADDR+1:0] s_level;
  logic [DATA-1:0] sb [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample and score just after.
  task automatic step(input logic wv, input logic rr);
    logic [DATA-1:0] exp_v;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = next_data;
    rd_ready = rr;
    #1;
    s_we    = ram_we;
    s_wrr   = wr_ready;
    s_level = level;
    if (hold_chk) check_eq("hold_stable", rd_data, held);
    hold_chk = rd_valid && !rr;
    held     = rd_data;
    if (rd_valid && rr) begin
      check_eq("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_v = sb.pop_front();
        check_eq("order", rd_data, exp_v);
      end
      last_pop = rd_data;
      pops++;
    end
    if (wv && wr_ready) begin
      sb.push_back(next_data);
      next_data = next_data + 1'b1;
      accepts++;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && level == 0) break;
      step(1'b0, 1'b1);
    end
    @(negedge clk); #1;
    check_eq("drain_empty", empty, 1);
    check_eq("drain_sb", sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_acc;
    int base_pop;
    logic prev_we;
    logic [3:0] pat;

    rst_n     = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = '0;
    rd_ready  = 1'b0;
    next_data = 16'h0001;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ram_we", ram_we, 0);
    rst_n    = 1'b1;
    wr_valid = 1'b0;

    // Fill to capacity with no consumer
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
    check_eq("fill_accepts", accepts, 10);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    @(negedge clk); #1;
    check_eq("fill_level", level, 10);
    check_eq("fill_full", full, 1);
    step(1'b1, 1'b0);
    check_eq("fill_wr_ready", s_wrr, 0);
    drain();
    check_eq("fill_pops", pops, 10);
    check_eq("fill_last", last_pop, 16'h000A);

    // Wrap-around: 4 rounds of write 5 / read 5
    for (int r = 0; r < 4; r++) begin
      base_acc = accepts;
      base_pop = pops;
      for (int g = 0; g < 50 && accepts < base_acc + 5; g++) step(1'b1, 1'b0);
      for (int g = 0; g < 50 && pops < base_pop + 5; g++) step(1'b0, 1'b1);
      check_eq("wrap_accepts", accepts - base_acc, 5);
      check_eq("wrap_pops", pops - base_pop, 5);
    end
    drain();

    // Simultaneous streaming from empty
    prev_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1);
      if (i == 0) check_eq("stream_first_we", s_we, 1);
      else        check_eq("stream_we_toggle", s_we, !prev_we);
      check_eq("stream_level_le2", (s_level <= 2), 1);
      prev_we = s_we;
    end
    drain();

    // Backpressure with rd_ready pattern 1,0,0,1
    pat = 4'b1001;
    for (int i = 0; i < 40; i++) step(1'b1, pat[i % 4]);
    drain();
    check_eq("bp_conserve", pops, accepts);

    // Reset in the cycle after a read grant
    step(1'b1, 1'b0);
    check_eq("mid_accept", s_wrr, 1);
    step(1'b0, 1'b0);
    check_eq("mid_read_grant", s_we, 0);
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mid_level", level, 0);
    check_eq("mid_rd_valid", rd_valid, 0);
    sb.delete();
    hold_chk  = 0;
    pops      = 0;
    accepts   = 0;
    next_data = 16'h00AB;
    for (int g = 0; g < 10 && accepts < 1; g++) step(1'b1, 1'b1);
    for (int g = 0; g < 10 && pops < 1; g++) step(1'b0, 1'b1);
    check_eq("mid_pops", pops, 1);
    check_eq("mid_first_word", last_pop, 16'h00AB);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
